// File: rtl/norm_seq_ctrl.sv
// Sequencer for the CIOS carry-normalization PE: walks T in an external word RAM, writing SOut back in place.
// Optional PE-done timeout is compiled in with `define NORM_SEQ_CTRL_TIMEOUT_EN.
module norm_seq_ctrl #(
    parameter int WORD_WIDTH     = 32,
    parameter int NUM_WORDS      = 16,
    parameter int ADDR_W         = $clog2(NUM_WORDS),
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [WORD_WIDTH-1:0] i_c_init,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic                  o_rd_en,
    output logic [ADDR_W-1:0]     o_rd_addr,
    input  logic [WORD_WIDTH-1:0] i_rd_data,
    output logic                  o_wr_en,
    output logic [ADDR_W-1:0]     o_wr_addr,
    output logic [WORD_WIDTH-1:0] o_wr_data,
    output logic                  o_pe_en,
    output logic [WORD_WIDTH-1:0] o_pe_cin,
    output logic [WORD_WIDTH-1:0] o_pe_s1,
    output logic [WORD_WIDTH-1:0] o_pe_s2,
    input  logic [WORD_WIDTH-1:0] i_pe_cout,
    input  logic [WORD_WIDTH-1:0] i_pe_sout,
    input  logic                  i_pe_done
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH0 = 4'd1,
        S_LAT0   = 4'd2,
        S_FETCH  = 4'd3,
        S_LAT    = 4'd4,
        S_ISSUE  = 4'd5,
        S_WAIT   = 4'd6,
        S_WRITE  = 4'd7,
        S_FINAL  = 4'd8,
        S_DONE   = 4'd9
    } state_t;

    localparam logic [ADDR_W-1:0] K_LAST    = ADDR_W'(NUM_WORDS - 2);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_WORDS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(32'd1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_W-1:0]     r_k;
    logic [ADDR_W-1:0]     w_k_nxt;
    logic                  w_timeout;
    logic [WORD_WIDTH-1:0] r_cin;
    logic [WORD_WIDTH-1:0] r_s1;
    logic [WORD_WIDTH-1:0] r_s2;
    logic [WORD_WIDTH-1:0] r_cout;

    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic                  r_rd_en;
    logic [ADDR_W-1:0]     r_rd_addr;
    logic                  r_wr_en;
    logic [ADDR_W-1:0]     r_wr_addr;
    logic [WORD_WIDTH-1:0] r_wr_data;
    logic                  r_pe_en;

    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic                  w_rd_en_nxt;
    logic [ADDR_W-1:0]     w_rd_addr_nxt;
    logic                  w_wr_en_nxt;
    logic [ADDR_W-1:0]     w_wr_addr_nxt;
    logic [WORD_WIDTH-1:0] w_wr_data_nxt;
    logic                  w_pe_en_nxt;

`ifdef NORM_SEQ_CTRL_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
    logic [TCNT_W-1:0] r_tcnt;

    // Timeout counter: zero outside WAIT, so it restarts on every WAIT entry.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tcnt <= '0;
        end else if (r_state != S_WAIT) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + TCNT_W'(32'd1);
        end
    end
`endif

    // Next-state and iteration-index logic.
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_FETCH0;
                    w_k_nxt     = '0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FETCH0: w_state_nxt = S_LAT0;
            S_LAT0:   w_state_nxt = S_FETCH;
            S_FETCH:  w_state_nxt = S_LAT;
            S_LAT:    w_state_nxt = S_ISSUE;
            S_ISSUE:  w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (i_pe_done) begin
                    w_state_nxt = S_WRITE;
                end else begin
`ifdef NORM_SEQ_CTRL_TIMEOUT_EN
                    if (r_tcnt == TCNT_LAST) begin
                        w_state_nxt = S_DONE;
                        w_timeout   = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
`else
                    w_state_nxt = S_WAIT;
`endif
                end
            end
            S_WRITE: begin
                if (r_k == K_LAST) begin
                    w_state_nxt = S_FINAL;
                end else begin
                    w_k_nxt     = r_k + ADDR_ONE;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FINAL: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered strobes line up with their state.
    assign w_busy_nxt    = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
    assign w_done_nxt    = (w_state_nxt == S_DONE);
    assign w_rd_en_nxt   = (w_state_nxt == S_FETCH0) || (w_state_nxt == S_FETCH);
    assign w_rd_addr_nxt = (w_state_nxt == S_FETCH) ? (w_k_nxt + ADDR_ONE) : '0;
    assign w_wr_en_nxt   = (w_state_nxt == S_WRITE) || (w_state_nxt == S_FINAL);
    assign w_wr_addr_nxt = (w_state_nxt == S_FINAL) ? ADDR_LAST :
                           (w_state_nxt == S_WRITE) ? r_k : '0;
    assign w_wr_data_nxt = (w_state_nxt == S_WRITE) ? i_pe_sout :
                           (w_state_nxt == S_FINAL) ? r_cout : '0;
    assign w_pe_en_nxt   = (w_state_nxt == S_ISSUE);

    // State, index and registered control outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_pe_en   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_k       <= w_k_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_timeout;
            r_rd_en   <= w_rd_en_nxt;
            r_rd_addr <= w_rd_addr_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_pe_en   <= w_pe_en_nxt;
        end
    end

    // Operand registers; COut of one step becomes S1 of the next, CIn only seeds step 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cin  <= '0;
            r_s1   <= '0;
            r_s2   <= '0;
            r_cout <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_cin <= i_c_init;
                    end
                end
                S_LAT0: r_s1 <= i_rd_data;
                S_LAT:  r_s2 <= i_rd_data;
                S_WAIT: begin
                    if (i_pe_done) begin
                        r_cout <= i_pe_cout;
                    end
                end
                S_WRITE: begin
                    r_s1  <= r_cout;
                    r_cin <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_err     = r_err;
    assign o_rd_en   = r_rd_en;
    assign o_rd_addr = r_rd_addr;
    assign o_wr_en   = r_wr_en;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_data;
    assign o_pe_en   = r_pe_en;
    assign o_pe_cin  = r_cin;
    assign o_pe_s1   = r_s1;
    assign o_pe_s2   = r_s2;

endmodule

// File: tb/tb_norm_seq_ctrl.sv
// Directed bench for norm_seq_ctrl: an N=4 and an N=2 instance, each with a word RAM and a D=3 PE model.
module tb_norm_seq_ctrl;
    localparam int W = 8;
    localparam int D = 3;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    // ---------------- instance A: N=4 ----------------
    logic         a_start, a_busy, a_done, a_err, a_rd_en, a_wr_en, a_pe_en, a_pe_done;
    logic [W-1:0] a_cinit, a_rd_data, a_wr_data, a_pe_cin, a_pe_s1, a_pe_s2, a_pe_cout, a_pe_sout;
    logic [1:0]   a_rd_addr, a_wr_addr;
    logic [W-1:0] a_mem [4];
    logic [W-1:0] a_init [4];
    logic         a_load, a_mute, a_inj;
    int           a_wr_cnt, a_calls;
    logic [2:0]   a_sr;
    logic [W-1:0] a_res_s, a_res_c;

    // ---------------- instance B: N=2 ----------------
    logic         b_start, b_busy, b_done, b_err, b_rd_en, b_wr_en, b_pe_en, b_pe_done;
    logic [W-1:0] b_cinit, b_rd_data, b_wr_data, b_pe_cin, b_pe_s1, b_pe_s2, b_pe_cout, b_pe_sout;
    logic [0:0]   b_rd_addr, b_wr_addr;
    logic [W-1:0] b_mem [2];
    logic [W-1:0] b_init [2];
    logic         b_load;
    int           b_wr_cnt, b_calls;
    logic [2:0]   b_sr;
    logic [W-1:0] b_res_s, b_res_c;
    logic [W-1:0] b_op_cin, b_op_s1, b_op_s2;

    norm_seq_ctrl #(.WORD_WIDTH(W), .NUM_WORDS(4), .TIMEOUT_CYCLES(8)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(a_start), .i_c_init(a_cinit),
        .o_busy(a_busy), .o_done(a_done), .o_err(a_err),
        .o_rd_en(a_rd_en), .o_rd_addr(a_rd_addr), .i_rd_data(a_rd_data),
        .o_wr_en(a_wr_en), .o_wr_addr(a_wr_addr), .o_wr_data(a_wr_data),
        .o_pe_en(a_pe_en), .o_pe_cin(a_pe_cin), .o_pe_s1(a_pe_s1), .o_pe_s2(a_pe_s2),
        .i_pe_cout(a_pe_cout), .i_pe_sout(a_pe_sout), .i_pe_done(a_pe_done)
    );

    norm_seq_ctrl #(.WORD_WIDTH(W), .NUM_WORDS(2), .TIMEOUT_CYCLES(8)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_c_init(b_cinit),
        .o_busy(b_busy), .o_done(b_done), .o_err(b_err),
        .o_rd_en(b_rd_en), .o_rd_addr(b_rd_addr), .i_rd_data(b_rd_data),
        .o_wr_en(b_wr_en), .o_wr_addr(b_wr_addr), .o_wr_data(b_wr_data),
        .o_pe_en(b_pe_en), .o_pe_cin(b_pe_cin), .o_pe_s1(b_pe_s1), .o_pe_s2(b_pe_s2),
        .i_pe_cout(b_pe_cout), .i_pe_sout(b_pe_sout), .i_pe_done(b_pe_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PE contract: {carry, SOut} = CIn + S1; COut = S2 + carry, wrap discarded; done D cycles after en.
    always @(posedge clk) begin
        if (a_load) begin
            a_mem    <= a_init;
            a_wr_cnt <= 0;
            a_calls  <= 0;
            a_sr     <= 3'b000;
        end else begin
            if (a_rd_en) a_rd_data <= a_mem[a_rd_addr];
            if (a_wr_en) begin
                a_mem[a_wr_addr] <= a_wr_data;
                a_wr_cnt         <= a_wr_cnt + 1;
            end
            a_sr <= {a_sr[1:0], a_pe_en};
            if (a_pe_en) begin
                a_res_s <= a_pe_cin + a_pe_s1;
                a_res_c <= a_pe_s2 + ((9'(a_pe_cin) + 9'(a_pe_s1) > 9'h0FF) ? 8'h01 : 8'h00);
                a_calls <= a_calls + 1;
            end
        end
    end
    assign a_pe_done = (a_sr[D-1] & ~a_mute) | a_inj;
    assign a_pe_sout = a_res_s;
    assign a_pe_cout = a_res_c;

    always @(posedge clk) begin
        if (b_load) begin
            b_mem    <= b_init;
            b_wr_cnt <= 0;
            b_calls  <= 0;
            b_sr     <= 3'b000;
        end else begin
            if (b_rd_en) b_rd_data <= b_mem[b_rd_addr];
            if (b_wr_en) begin
                b_mem[b_wr_addr] <= b_wr_data;
                b_wr_cnt         <= b_wr_cnt + 1;
            end
            b_sr <= {b_sr[1:0], b_pe_en};
            if (b_pe_en) begin
                b_res_s  <= b_pe_cin + b_pe_s1;
                b_res_c  <= b_pe_s2 + ((9'(b_pe_cin) + 9'(b_pe_s1) > 9'h0FF) ? 8'h01 : 8'h00);
                b_op_cin <= b_pe_cin;
                b_op_s1  <= b_pe_s1;
                b_op_s2  <= b_pe_s2;
                b_calls  <= b_calls + 1;
            end
        end
    end
    assign b_pe_done = b_sr[D-1];
    assign b_pe_sout = b_res_s;
    assign b_pe_cout = b_res_c;

    task automatic load_a(input logic [W-1:0] t0, input logic [W-1:0] t1,
                          input logic [W-1:0] t2, input logic [W-1:0] t3);
        a_init[0] = t0; a_init[1] = t1; a_init[2] = t2; a_init[3] = t3;
        a_load = 1'b1;
        @(negedge clk);
        a_load = 1'b0;
    endtask

    // One pass on A; start is high in cycle 0, extra start pulses at st1/st2, injected pe_done at inj.
    task automatic run_a(input logic [W-1:0] c, input int st1, input int st2, input int inj,
                         output int done_cyc, output int done_cnt, output logic err_seen,
                         output logic busy_c1, output logic busy_end, output int excl);
        int tail;
        done_cyc = -1; done_cnt = 0; err_seen = 1'b0; busy_c1 = 1'b0; busy_end = 1'b1;
        excl = 0; tail = -1;
        a_cinit = c;
        a_start = 1'b1;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (n == 1) busy_c1 = a_busy;
            if (a_rd_en && a_wr_en) excl++;
            if (a_done) begin
                done_cnt++;
                err_seen = err_seen | a_err;
                if (done_cyc < 0) begin
                    done_cyc = n;
                    tail     = n + 8;
                end
            end
            busy_end = a_busy;
            a_start  = (n == st1) || (n == st2);
            a_inj    = (n == inj);
            if (n == tail) break;
        end
        a_start = 1'b0;
        a_inj   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({a_busy, a_done, a_err, a_rd_en, a_wr_en, a_pe_en, a_rd_addr, a_wr_addr,
             a_wr_data, a_pe_cin, a_pe_s1, a_pe_s2} !== 42'd0) begin
            errors++;
            $display("FAIL reset_a: outputs not all zero, got busy=%b done=%b rd_en=%b wr_en=%b pe_en=%b, want 0",
                     a_busy, a_done, a_rd_en, a_wr_en, a_pe_en);
        end
        checks++;
        if ({b_busy, b_done, b_err, b_rd_en, b_wr_en, b_pe_en, b_rd_addr, b_wr_addr,
             b_wr_data, b_pe_cin, b_pe_s1, b_pe_s2} !== 40'd0) begin
            errors++;
            $display("FAIL reset_b: outputs not all zero, got busy=%b done=%b rd_en=%b wr_en=%b pe_en=%b, want 0",
                     b_busy, b_done, b_rd_en, b_wr_en, b_pe_en);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Plain pass: T unchanged, done at 4+(N-1)(D+4)=25.
    task automatic test_basic();
        int dc, dn, ex; logic es, b1, be;
        load_a(8'h10, 8'h20, 8'h30, 8'h40);
        run_a(8'h00, -1, -1, -1, dc, dn, es, b1, be, ex);
        checks++; if (dc !== 25) begin errors++; $display("FAIL basic_done_cycle: got %0d want 25", dc); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d want 1", dn); end
        checks++; if (es !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", es); end
        checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL basic_busy_c1: got %b want 1", b1); end
        checks++; if (be !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b want 0", be); end
        checks++; if (ex !== 0) begin errors++; $display("FAIL basic_rd_wr_overlap: got %0d want 0", ex); end
        checks++;
        if ({a_mem[0], a_mem[1], a_mem[2], a_mem[3]} !== 32'h10203040) begin
            errors++;
            $display("FAIL basic_ram: got %h want 10203040", {a_mem[0], a_mem[1], a_mem[2], a_mem[3]});
        end
        checks++; if (a_wr_cnt !== 4) begin errors++; $display("FAIL basic_writes: got %0d want 4", a_wr_cnt); end
        checks++; if (a_calls !== 3) begin errors++; $display("FAIL basic_pe_calls: got %0d want 3", a_calls); end
    endtask

    // Carry ripples from word 0 into word 1; word 1's own wrap is dropped.
    task automatic test_carry();
        int dc, dn, ex; logic es, b1, be;
        load_a(8'hFF, 8'hFF, 8'h12, 8'h34);
        run_a(8'h01, -1, -1, -1, dc, dn, es, b1, be, ex);
        checks++;
        if ({a_mem[0], a_mem[1], a_mem[2], a_mem[3]} !== 32'h00001234) begin
            errors++;
            $display("FAIL carry_ram: got %h want 00001234", {a_mem[0], a_mem[1], a_mem[2], a_mem[3]});
        end
        checks++; if (dc !== 25) begin errors++; $display("FAIL carry_done_cycle: got %0d want 25", dc); end
        checks++; if (a_wr_cnt !== 4) begin errors++; $display("FAIL carry_writes: got %0d want 4", a_wr_cnt); end
    endtask

    // start during ISSUE and in DONE, pe_done during FETCH: all ignored.
    task automatic test_ignored();
        int dc, dn, ex; logic es, b1, be;
        load_a(8'h10, 8'h20, 8'h30, 8'h40);
        run_a(8'h00, 5, 25, 3, dc, dn, es, b1, be, ex);
        checks++; if (dc !== 25) begin errors++; $display("FAIL ignored_done_cycle: got %0d want 25", dc); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL ignored_done_pulses: got %0d want 1", dn); end
        checks++; if (a_calls !== 3) begin errors++; $display("FAIL ignored_pe_calls: got %0d want 3", a_calls); end
        checks++; if (a_wr_cnt !== 4) begin errors++; $display("FAIL ignored_writes: got %0d want 4", a_wr_cnt); end
        checks++; if (be !== 1'b0) begin errors++; $display("FAIL ignored_busy_end: got %b want 0", be); end
        checks++;
        if ({a_mem[0], a_mem[1], a_mem[2], a_mem[3]} !== 32'h10203040) begin
            errors++;
            $display("FAIL ignored_ram: got %h want 10203040", {a_mem[0], a_mem[1], a_mem[2], a_mem[3]});
        end
    endtask

    // Reset in the second WAIT (cycles 13..15); rst sampled at the end of cycle 14.
    task automatic test_reset_mid();
        int dc, dn, ex, viol; logic es, b1, be;
        load_a(8'h10, 8'h20, 8'h30, 8'h40);
        a_cinit = 8'h00;
        a_start = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            a_start = 1'b0;
            if (n == 14) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({a_busy, a_done, a_err, a_rd_en, a_wr_en, a_pe_en, a_rd_addr, a_wr_addr,
             a_wr_data, a_pe_cin, a_pe_s1, a_pe_s2} !== 42'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: got busy=%b pe_s1=%h pe_s2=%h wr_data=%h, want all 0",
                     a_busy, a_pe_s1, a_pe_s2, a_wr_data);
        end
        viol = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (a_rd_en || a_wr_en || a_pe_en || a_busy) viol++;
        end
        checks++; if (viol !== 0) begin errors++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", viol); end
        checks++; if (a_wr_cnt !== 1) begin errors++; $display("FAIL rstmid_writes: got %0d want 1", a_wr_cnt); end
        load_a(8'hFF, 8'hFF, 8'h12, 8'h34);
        run_a(8'h01, -1, -1, -1, dc, dn, es, b1, be, ex);
        checks++; if (dc !== 25) begin errors++; $display("FAIL rstmid_rerun_done: got %0d want 25", dc); end
        checks++;
        if ({a_mem[0], a_mem[1], a_mem[2], a_mem[3]} !== 32'h00001234) begin
            errors++;
            $display("FAIL rstmid_rerun_ram: got %h want 00001234", {a_mem[0], a_mem[1], a_mem[2], a_mem[3]});
        end
    endtask

    // N=2: single PE call, then FINAL writes COut to word 1; done at 4+7=11.
    task automatic test_n2();
        int dc;
        b_init[0] = 8'hF0; b_init[1] = 8'h01;
        b_load = 1'b1;
        @(negedge clk);
        b_load  = 1'b0;
        b_cinit = 8'h20;
        b_start = 1'b1;
        dc = -1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            b_start = 1'b0;
            if (b_done && dc < 0) dc = n;
            if (dc >= 0 && n == dc + 4) break;
        end
        checks++; if (dc !== 11) begin errors++; $display("FAIL n2_done_cycle: got %0d want 11", dc); end
        checks++;
        if ({b_op_cin, b_op_s1, b_op_s2} !== 24'h20F001) begin
            errors++;
            $display("FAIL n2_pe_operands: got %h want 20f001", {b_op_cin, b_op_s1, b_op_s2});
        end
        checks++;
        if ({b_mem[0], b_mem[1]} !== 16'h1002) begin
            errors++;
            $display("FAIL n2_ram: got %h want 1002", {b_mem[0], b_mem[1]});
        end
        checks++; if (b_wr_cnt !== 2) begin errors++; $display("FAIL n2_writes: got %0d want 2", b_wr_cnt); end
        checks++; if (b_calls !== 1) begin errors++; $display("FAIL n2_pe_calls: got %0d want 1", b_calls); end
    endtask

`ifdef NORM_SEQ_CTRL_TIMEOUT_EN
    // Silent PE: pe_en in cycle 5, WAIT 6..13, done=err=1 in cycle 14.
    task automatic test_timeout();
        int dc, dn, ex; logic es, b1, be;
        load_a(8'h10, 8'h20, 8'h30, 8'h40);
        a_mute = 1'b1;
        run_a(8'h00, -1, -1, -1, dc, dn, es, b1, be, ex);
        a_mute = 1'b0;
        checks++; if (dc !== 14) begin errors++; $display("FAIL timeout_done_cycle: got %0d want 14", dc); end
        checks++; if (es !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b want 1", es); end
        checks++; if (a_wr_cnt !== 0) begin errors++; $display("FAIL timeout_writes: got %0d want 0", a_wr_cnt); end
        checks++; if (be !== 1'b0) begin errors++; $display("FAIL timeout_busy_end: got %b want 0", be); end
        checks++; if (a_calls !== 1) begin errors++; $display("FAIL timeout_pe_calls: got %0d want 1", a_calls); end
    endtask
`endif

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        a_start = 1'b0; a_cinit = 8'h00; a_load = 1'b0; a_mute = 1'b0; a_inj = 1'b0;
        b_start = 1'b0; b_cinit = 8'h00; b_load = 1'b0;
        for (int i = 0; i < 4; i++) a_init[i] = 8'h00;
        for (int i = 0; i < 2; i++) b_init[i] = 8'h00;
        @(negedge clk);
        test_reset();
        test_basic();
        test_carry();
        test_ignored();
        test_reset_mid();
        test_n2();
`ifdef NORM_SEQ_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/norm_seq_ctrl.md
Name: norm_seq_ctrl

Overview:
- Initiator and sequencer for the CIOS carry-normalization PE. It walks an N-word T array held in an external word RAM and feeds the PE one (CIn, S1, S2) triple at a time over its en/done handshake.
- It writes each returned SOut back to the RAM in place and chains COut into the next step.
- It sits between the CIOS datapath's T buffer and one normalization PE instance.

Parameters:
WORD_WIDTH, 32, width of every data word and PE operand
NUM_WORDS, 16, words in T (N); must be >= 2
ADDR_W, $clog2(NUM_WORDS), RAM word-address width
TIMEOUT_CYCLES, 64, PE done timeout; used only when the optional feature is compiled in

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin normalization; sampled in IDLE only
c_init  in  WORD_WIDTH  initial carry word; captured with start
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when the pass completes
err  out  1  one-cycle timeout pulse, coincident with done (optional feature only; else tied 0)
rd_en  out  1  RAM read strobe
rd_addr  out  ADDR_W  RAM read address
rd_data  in  WORD_WIDTH  RAM read data; valid exactly 1 cycle after rd_en
wr_en  out  1  RAM write strobe
wr_addr  out  ADDR_W  RAM write address
wr_data  out  WORD_WIDTH  RAM write data
pe_en  out  1  PE start; one-cycle pulse
pe_cin  out  WORD_WIDTH  PE carry in
pe_s1  out  WORD_WIDTH  PE S1 operand
pe_s2  out  WORD_WIDTH  PE S2 operand
pe_cout  in  WORD_WIDTH  PE COut; valid when pe_done=1
pe_sout  in  WORD_WIDTH  PE SOut; valid when pe_done=1
pe_done  in  1  PE completion pulse

Behaviour:
- Reset: all outputs 0; state IDLE; index k=0; internal regs 0. Reset mid-pass aborts immediately. No further rd_en, wr_en or pe_en is issued, and the RAM holds partially written data.
- States and transitions:
  - IDLE -> FETCH0 on start (busy=1 from next cycle); capture c_init into cin_r, set k=0.
  - FETCH0: rd_en=1, rd_addr=0 -> LAT0.
  - LAT0: s1_r <= rd_data -> FETCH.
  - FETCH: rd_en=1, rd_addr=k+1 -> LAT.
  - LAT: s2_r <= rd_data -> ISSUE.
  - ISSUE: pe_en=1 for exactly this cycle -> WAIT.
  - WAIT: hold until pe_done=1; then capture sout_r, cout_r -> WRITE.
  - WRITE: wr_en=1, wr_addr=k, wr_data=sout_r; s1_r <= cout_r; cin_r <= 0. If k==NUM_WORDS-2 -> FINAL, else k <= k+1 -> FETCH.
  - FINAL: wr_en=1, wr_addr=NUM_WORDS-1, wr_data=cout_r -> DONE.
  - DONE: done=1, busy=0 -> IDLE.
- Operand outputs: pe_cin/pe_s1/pe_s2 are driven from cin_r/s1_r/s2_r and held stable from ISSUE through WAIT.
- Iteration k therefore sends CIn=(k==0 ? c_init : 0), S1=(k==0 ? T[0] : previous COut), S2=T[k+1].
- In-place safe: writes go only to address k after T[k] has already been consumed.
- Arithmetic: entirely in the PE. The controller never adds, and any overflow beyond COut is discarded, matching the PE contract.
- Latency: with pe_done arriving D>=1 cycles after pe_en, each iteration takes D+4 cycles. done is high in cycle 4+(N-1)(D+4), counting the start-accepted cycle as 0.
- Strobe exclusivity: rd_en and wr_en are never high in the same cycle. At most one pe_en is outstanding.
- Ignored events:
  - start while busy is ignored.
  - pe_done outside WAIT is ignored.
  - pe_done in the same cycle as pe_en (ISSUE) is ignored.
  - start in the DONE cycle is ignored; it is accepted only in IDLE.

Optional Feature:
NORM_SEQ_CTRL_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without pe_done, go to DONE with err=1 and done=1 in the same cycle. Skip WRITE/FINAL.
  - A late pe_done is ignored.
- Undefined: no counter; WAIT waits indefinitely; err tied 0.

Test Plan:
- WORD_WIDTH=8, N=4, PE model with D=3; RAM T={0x10,0x20,0x30,0x40}, c_init=0 -> writes {0x10,0x20,0x30,0x40} to addr 0..3; done at cycle 25; err=0.
- Same but T={0xFF,0xFF,0x12,0x34}, c_init=0x01 -> RAM ends {0x00,0x00,0x12,0x34}: carry ripples into word 1, and word 1's own wrap is discarded.
- N=2, T={0xF0,0x01}, c_init=0x20 -> one PE call with CIn=0x20, S1=0xF0, S2=0x01; RAM ends {0x10,0x02}; exactly 2 writes.
- start pulsed during busy and pe_done injected in FETCH -> no second pass; no extra PE call; results as in the first test.
- Assert rst during the second WAIT -> next cycle all outputs 0, state IDLE; no further writes; a later start runs a full clean pass.
- Timeout feature on, TIMEOUT_CYCLES=8, PE never responds -> done=err=1 exactly 8 WAIT cycles after pe_en; zero writes; busy=0 afterward.
